// File: rtl/marker_pkg.sv
// Shared sizes, FSM states and colour constants for the concentric-ring marker generator.
// XW/YW follow the hcount/vcount port widths; TW covers the outermost ring threshold.
package marker_pkg;

  localparam int NUM_TARGETS   = 4;
  localparam int NUM_RINGS     = 4;
  localparam int MIN_WIDTH     = 5;
  localparam int MAX_WIDTH     = 100;
  localparam int SCREEN_WIDTH  = 1280;
  localparam int SCREEN_HEIGHT = 720;
  localparam int COLOUR_DEPTH  = 8;

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int TW = $clog2(NUM_RINGS * MAX_WIDTH + 1);
  localparam int RW = $clog2(NUM_RINGS + 1);
  localparam int SW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int KW = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, BUILD, READY} state_t;

  localparam logic [COLOUR_DEPTH-1:0]   MID_LEVEL = COLOUR_DEPTH'(1 << (COLOUR_DEPTH - 1));
  localparam logic [3*COLOUR_DEPTH-1:0] WHITE     = '1;
  localparam logic [3*COLOUR_DEPTH-1:0] BLACK     = '0;
  localparam logic [3*COLOUR_DEPTH-1:0] BG_COLOUR = {3{MID_LEVEL}};

  function automatic logic width_ok(input logic [WW-1:0] w);
    return (w >= WW'(MIN_WIDTH)) && (w <= WW'(MAX_WIDTH));
  endfunction

endpackage

// File: rtl/marker_pattern_gen_if.sv
// Pixel-stream and target-descriptor bundle between a pattern source (master) and the
// marker generator (slave).
interface marker_pattern_gen_if;
  import marker_pkg::*;

  logic                            vsync_in;
  logic [XW-1:0]                   hcount_in;
  logic [YW-1:0]                   vcount_in;
  logic [NUM_TARGETS*XW-1:0]       x_in;
  logic [NUM_TARGETS*YW-1:0]       y_in;
  logic [NUM_TARGETS*WW-1:0]       width_in;
  logic [NUM_TARGETS-1:0]          valid_in;
  logic [3*COLOUR_DEPTH-1:0]       rgb_out;
  logic [XW-1:0]                   hcount_out;
  logic [YW-1:0]                   vcount_out;
  logic                            vsync_out;
  logic                            ready_out;

  modport master (
    output vsync_in, hcount_in, vcount_in, x_in, y_in, width_in, valid_in,
    input  rgb_out, hcount_out, vcount_out, vsync_out, ready_out
  );

  modport slave (
    input  vsync_in, hcount_in, vcount_in, x_in, y_in, width_in, valid_in,
    output rgb_out, hcount_out, vcount_out, vsync_out, ready_out
  );

endinterface

// File: rtl/marker_ring_classify.sv
// Per-slot datapath: registered Chebyshev distance to the centre, then a combinational
// count of ring thresholds at or below it, giving hit and ring parity.
module marker_ring_classify
  import marker_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [XW-1:0]         h,
  input  logic [YW-1:0]         v,
  input  logic [XW-1:0]         cx,
  input  logic [YW-1:0]         cy,
  input  logic [NUM_RINGS*TW-1:0] thr,
  input  logic                  valid,
  output logic                  hit,
  output logic                  parity
);

  localparam int DW = (XW > YW) ? XW : YW;

  logic signed [XW:0] dx_s;
  logic signed [YW:0] dy_s;
  logic [XW-1:0]      dx;
  logic [YW-1:0]      dy;
  logic [DW-1:0]      d_next, d_reg;
  logic [TW-1:0]      d_sat;
  logic [NUM_RINGS-1:0] ge;
  logic [RW-1:0]      ring;

  always_comb begin
    dx_s   = $signed({1'b0, h}) - $signed({1'b0, cx});
    dy_s   = $signed({1'b0, v}) - $signed({1'b0, cy});
    dx     = dx_s[XW] ? XW'(-dx_s) : dx_s[XW-1:0];
    dy     = dy_s[YW] ? YW'(-dy_s) : dy_s[YW-1:0];
    d_next = (DW'(dx) > DW'(dy)) ? DW'(dx) : DW'(dy);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) d_reg <= '0;
    else        d_reg <= d_next;
  end

  // Distances beyond the threshold range pin to all-ones, which exceeds every ring.
  generate
    if (DW > TW) begin : g_sat
      assign d_sat = (|d_reg[DW-1:TW]) ? '1 : d_reg[TW-1:0];
    end else begin : g_ext
      assign d_sat = TW'(d_reg);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RINGS; gi++) begin : g_cmp
      assign ge[gi] = (thr[gi*TW +: TW] <= d_sat);
    end
  endgenerate

  always_comb begin
    ring = '0;
    for (int k = 0; k < NUM_RINGS; k++) ring = ring + RW'(ge[k]);
  end

  assign hit    = valid & (ring < RW'(NUM_RINGS));
  assign parity = ring[0];

endmodule

// File: rtl/marker_pattern_gen.sv
// Paints up to NUM_TARGETS square bullseyes into a pixel stream. A vsync rise latches the
// descriptors, a single adder then builds the ring thresholds before the frame is shown.
module marker_pattern_gen
  import marker_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  marker_pattern_gen_if.slave bus
);

  state_t state_reg, state_next;
  logic   vsync_q_reg, vsync_rise, ready_reg;

  logic [XW-1:0]          sx_reg [NUM_TARGETS];
  logic [YW-1:0]          sy_reg [NUM_TARGETS];
  logic [WW-1:0]          sw_reg [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] sv_reg;

  logic [TW-1:0]          thr_reg [NUM_TARGETS][NUM_RINGS];
  logic [NUM_RINGS*TW-1:0] thr_flat [NUM_TARGETS];
  logic [TW-1:0]          acc_reg, acc_base, thr_sum;
  logic [SW-1:0]          slot_reg;
  logic [KW-1:0]          ring_reg;
  logic                   build_last;

  logic [XW-1:0]          h_d1_reg, hcount_out_reg;
  logic [YW-1:0]          v_d1_reg, vcount_out_reg;
  logic                   vs_d1_reg, vsync_out_reg;
  logic [NUM_TARGETS-1:0] hit, parity;
  logic [3*COLOUR_DEPTH-1:0] rgb_next, rgb_reg;

  assign vsync_rise = bus.vsync_in & ~vsync_q_reg;
  assign build_last = (slot_reg == SW'(NUM_TARGETS - 1)) && (ring_reg == KW'(NUM_RINGS - 1));

  always_comb begin
    state_next = state_reg;
    if (vsync_rise) begin
      state_next = LATCH;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        LATCH:   state_next = BUILD;
        BUILD:   if (build_last) state_next = READY;
        READY:   state_next = READY;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      vsync_q_reg <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      vsync_q_reg <= bus.vsync_in;
      ready_reg   <= (state_next == READY);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sv_reg <= '0;
    end else if (state_reg == LATCH) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        sx_reg[i] <= bus.x_in[i*XW +: XW];
        sy_reg[i] <= bus.y_in[i*YW +: YW];
        sw_reg[i] <= bus.width_in[i*WW +: WW];
        sv_reg[i] <= bus.valid_in[i] & width_ok(bus.width_in[i*WW +: WW]);
      end
    end
  end

  // Slot-major walk: each entry adds the stripe width to the previous ring's threshold.
  always_comb begin
    acc_base = (ring_reg == '0) ? '0 : acc_reg;
    thr_sum  = acc_base + TW'(sw_reg[slot_reg]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_reg <= '0;
      ring_reg <= '0;
      acc_reg  <= '0;
    end else if (state_reg == LATCH) begin
      slot_reg <= '0;
      ring_reg <= '0;
    end else if (state_reg == BUILD) begin
      acc_reg <= thr_sum;
      if (ring_reg == KW'(NUM_RINGS - 1)) begin
        ring_reg <= '0;
        slot_reg <= slot_reg + SW'(1);
      end else begin
        ring_reg <= ring_reg + KW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (state_reg == BUILD) thr_reg[slot_reg][ring_reg] <= thr_sum;
  end

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_slot
      for (gk = 0; gk < NUM_RINGS; gk++) begin : g_thr
        assign thr_flat[gi][gk*TW +: TW] = thr_reg[gi][gk];
      end

      marker_ring_classify u_classify (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .h      (bus.hcount_in),
        .v      (bus.vcount_in),
        .cx     (sx_reg[gi]),
        .cy     (sy_reg[gi]),
        .thr    (thr_flat[gi]),
        .valid  (sv_reg[gi]),
        .hit    (hit[gi]),
        .parity (parity[gi])
      );
    end
  endgenerate

  // Walk from the highest slot down so the lowest-index hit is the one that sticks.
  always_comb begin
    rgb_next = BG_COLOUR;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (hit[i]) rgb_next = parity[i] ? BLACK : WHITE;
    end
    if ((state_reg != READY) || vs_d1_reg) rgb_next = BG_COLOUR;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_d1_reg       <= '0;
      v_d1_reg       <= '0;
      vs_d1_reg      <= 1'b0;
      hcount_out_reg <= '0;
      vcount_out_reg <= '0;
      vsync_out_reg  <= 1'b0;
      rgb_reg        <= '0;
    end else begin
      h_d1_reg       <= bus.hcount_in;
      v_d1_reg       <= bus.vcount_in;
      vs_d1_reg      <= bus.vsync_in;
      hcount_out_reg <= h_d1_reg;
      vcount_out_reg <= v_d1_reg;
      vsync_out_reg  <= vs_d1_reg;
      rgb_reg        <= rgb_next;
    end
  end

  assign bus.rgb_out    = rgb_reg;
  assign bus.hcount_out = hcount_out_reg;
  assign bus.vcount_out = vcount_out_reg;
  assign bus.vsync_out  = vsync_out_reg;
  assign bus.ready_out  = ready_reg;

endmodule

// File: tb/tb_marker_pattern_gen.sv
// Bench for marker_pattern_gen: a ring model (distance / width) checked every cycle,
// plus hand-computed pixel probes for the boundary cases.
module tb_marker_pattern_gen;
  import marker_pkg::*;

  localparam logic [23:0] C_BG = 24'h808080;
  localparam logic [23:0] C_W  = 24'hFFFFFF;
  localparam logic [23:0] C_B  = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  marker_pattern_gen_if bus();

  marker_pattern_gen dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: descriptors as latched one edge after each vsync rise, ready 17 edges after it.
  int  m_x [NUM_TARGETS];
  int  m_y [NUM_TARGETS];
  int  m_w [NUM_TARGETS];
  bit  m_v [NUM_TARGETS];
  int  since   = -1;
  bit  prev_vs = 1'b0;
  bit  cent    = 1'b0;

  typedef struct {
    int h;
    int v;
    bit vs;
    bit rdy;
    bit rst;
    bit cent;
  } hist_t;

  hist_t h1 = '{h: 0, v: 0, vs: 1'b0, rdy: 1'b0, rst: 1'b1, cent: 1'b0};
  hist_t h2 = '{h: 0, v: 0, vs: 1'b0, rdy: 1'b0, rst: 1'b1, cent: 1'b0};

  longint sum_x = 0, sum_y = 0, n_white = 0;

  function automatic logic [23:0] model_rgb(input int h, input int v, input bit vs, input bit rdy);
    int dx, dy, d, ring;
    if (!rdy || vs) return C_BG;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (m_v[i] && m_w[i] >= 5 && m_w[i] <= 100) begin
        dx = h - m_x[i];
        if (dx < 0) dx = -dx;
        dy = v - m_y[i];
        if (dy < 0) dy = -dy;
        d = (dx > dy) ? dx : dy;
        ring = d / m_w[i];
        if (ring < 4) return (ring % 2 == 0) ? C_W : C_B;
      end
    end
    return C_BG;
  endfunction

  always @(posedge clk) begin
    h2 = h1;
    h1.h    = int'(bus.hcount_in);
    h1.v    = int'(bus.vcount_in);
    h1.vs   = bus.vsync_in;
    h1.rst  = rst;
    h1.cent = cent;
    if (rst) begin
      since   = -1;
      prev_vs = 1'b0;
    end else begin
      if (bus.vsync_in && !prev_vs) since = 0;
      else if (since >= 0 && since < 1000) since++;
      if (since == 1) begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          m_x[i] = int'(bus.x_in[i*XW +: XW]);
          m_y[i] = int'(bus.y_in[i*YW +: YW]);
          m_w[i] = int'(bus.width_in[i*WW +: WW]);
          m_v[i] = bus.valid_in[i];
        end
      end
      prev_vs = bus.vsync_in;
    end
    h1.rdy = (since >= 17);
  end

  always @(negedge clk) begin : cmp
    logic [23:0] e;
    if (h1.rst) begin
      chk("reset_rgb",    32'(bus.rgb_out),    32'h0);
      chk("reset_ready",  32'(bus.ready_out),  32'h0);
      chk("reset_hcount", 32'(bus.hcount_out), 32'h0);
      chk("reset_vcount", 32'(bus.vcount_out), 32'h0);
      chk("reset_vsync",  32'(bus.vsync_out),  32'h0);
    end else if (!h2.rst) begin
      e = model_rgb(h2.h, h2.v, h2.vs, h2.rdy);
      chk($sformatf("rgb(%0d,%0d)", h2.h, h2.v), 32'(bus.rgb_out), 32'(e));
      chk("ready",        32'(bus.ready_out),  32'(h1.rdy));
      chk("hcount_align", 32'(bus.hcount_out), 32'(h2.h));
      chk("vcount_align", 32'(bus.vcount_out), 32'(h2.v));
      chk("vsync_align",  32'(bus.vsync_out),  32'(h2.vs));
      if (h2.cent && bus.rgb_out == C_W) begin
        sum_x   += h2.h;
        sum_y   += h2.v;
        n_white += 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v);
    bus.hcount_in = XW'(h);
    bus.vcount_in = YW'(v);
  endtask

  task automatic probe(input int h, input int v, input logic [23:0] exp, input string name);
    drive(h, v);
    tick();
    tick();
    chk(name, 32'(bus.rgb_out), 32'(exp));
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int w, input bit v);
    bus.x_in[i*XW +: XW]     = XW'(x);
    bus.y_in[i*YW +: YW]     = YW'(y);
    bus.width_in[i*WW +: WW] = WW'(w);
    bus.valid_in[i]          = v;
  endtask

  task automatic vpulse();
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in = 1'b0;
  endtask

  // Called right after vpulse: the rise was sampled on the edge inside vpulse.
  task automatic wait_ready(input string name);
    repeat (16) tick();
    chk({name, "_ready_low_16"}, 32'(bus.ready_out), 32'h0);
    tick();
    chk({name, "_ready_high_17"}, 32'(bus.ready_out), 32'h1);
  endtask

  initial begin
    int cx, cy;
    bus.vsync_in  = 1'b0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.width_in  = '0;
    bus.valid_in  = '0;

    repeat (3) tick();
    chk("lit_reset_rgb",   32'(bus.rgb_out),   32'h0);
    chk("lit_reset_ready", 32'(bus.ready_out), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    probe(100, 50, C_BG, "idle_bg");

    // Single target, ring edges along the row through the centre.
    set_slot(0, 100, 50, 10, 1'b1);
    vpulse();
    wait_ready("f1");
    probe(100, 50, C_W,  "f1_centre");
    probe(110, 50, C_B,  "f1_d10_ring1");
    probe(139, 50, C_B,  "f1_d39_ring3");
    probe(140, 50, C_BG, "f1_d40_outside");
    probe(617, 50, C_BG, "f1_d517_saturated");
    probe(1279, 719, C_BG, "f1_far_corner");
    probe(0, 0, C_BG, "f1_clip_corner");

    // Overlapping slots: the lower index decides.
    set_slot(0, 200, 200, 5, 1'b1);
    set_slot(1, 200, 200, 20, 1'b1);
    set_slot(3, 600, 300, 7, 1'b1);
    vpulse();
    wait_ready("f2");
    probe(215, 200, C_B,  "f2_prio_slot0");
    probe(200, 200, C_W,  "f2_centre");
    probe(225, 200, C_B,  "f2_slot1_ring1");
    probe(250, 200, C_W,  "f2_slot1_ring2");
    probe(607, 300, C_B,  "f2_slot3_ring1");
    probe(628, 300, C_BG, "f2_slot3_outside");
    for (int h = 170; h < 300; h++) begin
      drive(h, 200);
      tick();
    end

    // Out-of-range widths are dropped without disturbing the other slots.
    set_slot(2, 400, 400, 4, 1'b1);
    vpulse();
    wait_ready("f3");
    probe(400, 400, C_BG, "f3_w4_ignored");
    probe(200, 200, C_W,  "f3_slot0_kept");
    probe(600, 300, C_W,  "f3_slot3_kept");

    set_slot(2, 400, 400, 101, 1'b1);
    vpulse();
    wait_ready("f4");
    probe(400, 400, C_BG, "f4_w101_ignored");
    probe(605, 305, C_W,  "f4_slot3_kept");

    set_slot(2, 400, 400, 100, 1'b1);
    vpulse();
    wait_ready("f5");
    probe(499, 400, C_W,  "f5_w100_d99");
    probe(500, 400, C_B,  "f5_w100_d100");
    probe(799, 400, C_B,  "f5_w100_d399");
    probe(800, 400, C_BG, "f5_w100_d400");
    repeat (300) begin
      drive(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)));
      tick();
    end

    // A second rise during BUILD restarts and latches the newer descriptors.
    set_slot(0, 100, 50, 10, 1'b1);
    set_slot(1, 0, 0, 0, 1'b0);
    set_slot(2, 0, 0, 0, 1'b0);
    set_slot(3, 0, 0, 0, 1'b0);
    vpulse();
    repeat (4) tick();
    set_slot(0, 100, 50, 20, 1'b1);
    vpulse();
    wait_ready("f6_restart");
    probe(110, 50, C_W, "f6_relatched_w20");
    probe(139, 50, C_B, "f6_w20_d39");
    set_slot(0, 900, 50, 20, 1'b1);
    probe(110, 50, C_W, "f6_shadow_held");

    // Held vsync: FSM reaches READY while the pixels are still blanked.
    set_slot(0, 100, 50, 10, 1'b1);
    bus.vsync_in = 1'b1;
    repeat (20) tick();
    probe(100, 50, C_BG, "f7_vsync_high_bg");
    bus.vsync_in = 1'b0;
    probe(100, 50, C_W, "f7_vsync_low_white");

    // Centre recovery from the white pixels of a full-window scan.
    cent = 1'b1;
    for (int v = 10; v <= 90; v++) begin
      for (int h = 60; h <= 140; h++) begin
        drive(h, v);
        tick();
      end
    end
    cent = 1'b0;
    drive(0, 0);
    repeat (3) tick();
    n_cmp++;
    if (n_white == 0) begin
      n_bad++;
      $display("FAIL centroid: got 0 white pixels, required > 0");
    end else begin
      cx = int'(sum_x / n_white);
      cy = int'(sum_y / n_white);
      if (cx < 99 || cx > 101 || cy < 49 || cy > 51) begin
        n_bad++;
        $display("FAIL centroid: got (%0d,%0d), required (100,50) +/-1", cx, cy);
      end
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
